// File: rtl/regfile_wb.sv
// 32x32 register file with writeback source mux, link override and a self-clearing INIT sequence.
// Optional write-through bypass when built with REGFILE_BYPASS_EN.
module regfile_wb #(
   parameter logic [31:0] INIT_VAL = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic        regwrite,
   input  logic [1:0]  wbsel,
   input  logic        link,
   input  logic [31:0] alu_sum,
   input  logic [31:0] mem_data,
   input  logic [31:0] pc_plus4,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        ready
);

   typedef enum logic {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  clr_ptr_q, clr_ptr_d;
   logic        ready_q, ready_d;
   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   logic [4:0]  wr_dst;
   logic [31:0] wr_dat;
   logic        wr_en;

   // Link overrides both destination and source so JAL/BAL ignore wa/wbsel.
   always_comb begin
      wr_dst = wa;
      wr_dat = alu_sum;
      case (wbsel)
         2'b00:   wr_dat = alu_sum;
         2'b01:   wr_dat = mem_data;
         2'b10:   wr_dat = pc_plus4;
         default: wr_dat = alu_sum;
      endcase
      if (link) begin
         wr_dst = 5'd31;
         wr_dat = pc_plus4;
      end
      wr_en = ready_q && regwrite && (wr_dst != 5'd0) && (link || (wbsel != 2'b11));
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      for (int i = 0; i < 32; i++) begin
         regs_d[i] = regs_q[i];
      end
      case (state_q)
         S_INIT: begin
            regs_d[clr_ptr_q] = INIT_VAL;
            clr_ptr_d         = clr_ptr_q + 5'd1;
            if (clr_ptr_q == 5'd31) begin
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (wr_en) begin
               regs_d[wr_dst] = wr_dat;
            end
         end
         default: state_d = S_INIT;
      endcase
      ready_d = (state_d == S_READY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_INIT;
         clr_ptr_q <= 5'd0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         ready_q   <= ready_d;
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      rd1 = 32'h0;
      rd2 = 32'h0;
      if (ready_q) begin
         if (ra1 != 5'd0) rd1 = regs_q[ra1];
         if (ra2 != 5'd0) rd2 = regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
         // wr_en already excludes r0, so a match here is always a live destination.
         if (wr_en && (ra1 == wr_dst)) rd1 = wr_dat;
         if (wr_en && (ra2 == wr_dst)) rd2 = wr_dat;
`endif
      end
   end

   assign ready = ready_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb; expectations follow the build's REGFILE_BYPASS_EN setting.
module tb_regfile_wb;

   logic        clk;
   logic        reset;
   logic [4:0]  ra1, ra2, wa;
   logic        regwrite;
   logic [1:0]  wbsel;
   logic        link;
   logic [31:0] alu_sum, mem_data, pc_plus4;
   logic [31:0] rd1, rd2;
   logic        ready;

   int checks_cnt;
   int errors_cnt;

   regfile_wb #(.INIT_VAL(32'h00000000)) dut (
      .clk      (clk),
      .reset    (reset),
      .ra1      (ra1),
      .ra2      (ra2),
      .wa       (wa),
      .regwrite (regwrite),
      .wbsel    (wbsel),
      .link     (link),
      .alu_sum  (alu_sum),
      .mem_data (mem_data),
      .pc_plus4 (pc_plus4),
      .rd1      (rd1),
      .rd2      (rd2),
      .ready    (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [1:0] sel, input logic lnk,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
      wa = a; wbsel = sel; link = lnk; alu_sum = alu; mem_data = mem; pc_plus4 = pc;
      regwrite = 1'b1;
      tick();
      regwrite = 1'b0;
      link     = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      ra1 = a;
      ra2 = a;
      #1;
      chk_val({tag, "_rd1"}, rd1, exp);
      chk_val({tag, "_rd2"}, rd2, exp);
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      reset = 1'b1; ra1 = 5'd1; ra2 = 5'd2; wa = 5'd0; regwrite = 1'b0;
      wbsel = 2'b00; link = 1'b0; alu_sum = 32'h0; mem_data = 32'h0; pc_plus4 = 32'h0;

      // Reset and full INIT sequence, with a dropped write at INIT cycle 10
      tick();
      chk_val("rst_ready", {31'd0, ready}, 32'd0);
      chk_val("rst_rd1", rd1, 32'h0);
      chk_val("rst_rd2", rd2, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i == 10) begin
            wa = 5'd10; wbsel = 2'b00; alu_sum = 32'hBAD0BAD0; regwrite = 1'b1;
         end else begin
            regwrite = 1'b0;
         end
         ra1 = 5'(i); ra2 = 5'(31 - i);
         #1;
         chk_val($sformatf("init_ready_%0d", i), {31'd0, ready}, 32'd0);
         chk_val($sformatf("init_rd1_%0d", i), rd1, 32'h0);
         chk_val($sformatf("init_rd2_%0d", i), rd2, 32'h0);
         tick();
      end
      regwrite = 1'b0;
      chk_val("init_done_ready", {31'd0, ready}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         rd_chk($sformatf("init_val_r%0d", i), 5'(i), 32'h0);
      end
      rd_chk("dropped_r10", 5'd10, 32'h0);

      // Writeback source mux and 1-cycle latency
      wr(5'd5, 2'b00, 1'b0, 32'h1234ABCD, 32'h11111111, 32'h22222222);
      rd_chk("alu_r5", 5'd5, 32'h1234ABCD);
      wr(5'd6, 2'b01, 1'b0, 32'h33333333, 32'hDEADBEEF, 32'h44444444);
      rd_chk("mem_r6", 5'd6, 32'hDEADBEEF);
      wr(5'd12, 2'b10, 1'b0, 32'h55555555, 32'h66666666, 32'h00400004);
      rd_chk("pc_r12", 5'd12, 32'h00400004);

      // Link forces r31 <- pc_plus4 and leaves wa untouched
      wr(5'd7, 2'b00, 1'b0, 32'h77777777, 32'h0, 32'h0);
      wr(5'd7, 2'b00, 1'b1, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00400010);
      rd_chk("link_r31", 5'd31, 32'h00400010);
      rd_chk("link_r7", 5'd7, 32'h77777777);
      wr(5'd3, 2'b11, 1'b1, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00400020);
      rd_chk("link_sel11_r31", 5'd31, 32'h00400020);
      rd_chk("link_sel11_r3", 5'd3, 32'h0);

      // Register 0 is hardwired
      wr(5'd0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0);
      rd_chk("zero_r0", 5'd0, 32'h0);

      // wbsel=11 suppresses the write
      wr(5'd8, 2'b00, 1'b0, 32'h88888888, 32'h0, 32'h0);
      wr(5'd8, 2'b11, 1'b0, 32'h12121212, 32'h34343434, 32'h56565656);
      rd_chk("sel11_r8", 5'd8, 32'h88888888);

      // Distinct addresses on the two ports
      ra1 = 5'd5; ra2 = 5'd6;
      #1;
      chk_val("dual_rd1", rd1, 32'h1234ABCD);
      chk_val("dual_rd2", rd2, 32'hDEADBEEF);

      // Same-cycle read of the register being written
      wr(5'd9, 2'b00, 1'b0, 32'h99999999, 32'h0, 32'h0);
      wa = 5'd9; wbsel = 2'b00; alu_sum = 32'hCAFEF00D; regwrite = 1'b1;
      ra1 = 5'd5; ra2 = 5'd9;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk_val("bypass_rd2", rd2, 32'hCAFEF00D);
`else
      chk_val("nobypass_rd2", rd2, 32'h99999999);
`endif
      chk_val("bypass_rd1_other", rd1, 32'h1234ABCD);
      tick();
      regwrite = 1'b0;
      rd_chk("after_wr_r9", 5'd9, 32'hCAFEF00D);

      // Reset from READY, then reset again at INIT cycle 20
      reset = 1'b1;
      tick();
      chk_val("rst2_ready", {31'd0, ready}, 32'd0);
      rd_chk("rst2_rd", 5'd5, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk_val("mid_init_ready", {31'd0, ready}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         chk_val($sformatf("reinit_ready_%0d", i), {31'd0, ready}, 32'd0);
         tick();
      end
      chk_val("reinit_done_ready", {31'd0, ready}, 32'd1);
      rd_chk("reinit_r5", 5'd5, 32'h0);
      rd_chk("reinit_r31", 5'd31, 32'h0);
      rd_chk("reinit_r9", 5'd9, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 The block SHALL expose parameter INIT_VAL, default 32'h00000000, giving the value written to every register during initialisation.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port ra1, input, 5 bits, the read address for port 1 (rs).
REQ-005 The block SHALL have port ra2, input, 5 bits, the read address for port 2 (rt).
REQ-006 The block SHALL have port wa, input, 5 bits, the write address (rd/rt).
REQ-007 The block SHALL have port regwrite, input, 1 bit, the write request.
REQ-008 The block SHALL have port wbsel, input, 2 bits, the writeback source select.
REQ-009 The block SHALL have port link, input, 1 bit, the jump/branch-and-link request.
REQ-010 The block SHALL have port alu_sum, input, 32 bits, the ALU result.
REQ-011 The block SHALL have port mem_data, input, 32 bits, the data-memory load result.
REQ-012 The block SHALL have port pc_plus4, input, 32 bits, the return address.
REQ-013 The block SHALL have port rd1, output, 32 bits, the port-1 read data (combinational).
REQ-014 The block SHALL have port rd2, output, 32 bits, the port-2 read data (combinational).
REQ-015 The block SHALL have port ready, output, 1 bit, registered, high once initialisation completes.

Function
REQ-016 Storage SHALL be 32 registers x 32 bits; register 0 SHALL always read 0.
REQ-017 A two-state FSM SHALL be implemented: INIT and READY, with a 5-bit clear pointer clr_ptr.
REQ-018 In INIT, each rising edge with reset low SHALL write INIT_VAL to reg[clr_ptr] and increment clr_ptr.
REQ-019 The rising edge that clears reg[31] SHALL move the FSM to READY, so ready rises after exactly 32 edges following reset release.
REQ-020 Write data SHALL be selected as: wbsel 00 -> alu_sum; 01 -> mem_data; 10 -> pc_plus4; 11 -> no write.
REQ-021 When link=1, the destination SHALL be forced to 31 and the data to pc_plus4, regardless of wa and wbsel.
REQ-022 An effective write SHALL require ready=1, regwrite=1, a destination other than 0, and (link=1 or wbsel other than 11).
REQ-023 Effective writes SHALL commit on the rising edge, giving 1-cycle write latency.
REQ-024 Write requests while ready=0 SHALL be dropped, not queued.
REQ-025 rd1 and rd2 SHALL be 0 while ready=0, and otherwise reg[ra1]/reg[ra2], with address 0 returning 0.
REQ-026 Without bypass, a same-cycle read of the address being written SHALL return the old value.
REQ-027 When ra1 and ra2 are equal, both ports SHALL return identical data.

Reset
REQ-028 reset=1 at a rising edge SHALL set state INIT, clr_ptr 0 and ready 0, and SHALL take priority over any write.
REQ-029 reset during INIT SHALL restart clearing from register 0.
REQ-030 reset during READY SHALL re-enter INIT; register contents are not guaranteed until ready returns high.
REQ-031 Outputs after reset SHALL be ready=0, rd1=0 and rd2=0.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN SHALL control write-through bypass.
REQ-033 With REGFILE_BYPASS_EN defined, when a write is effective in the current cycle and a read address equals the (nonzero) destination, that read port SHALL return the write data combinationally.
REQ-034 Without REGFILE_BYPASS_EN, no bypass path SHALL exist and REQ-026 SHALL apply.

Verification
REQ-035 Init check: pulse reset for 1 cycle -> ready=0 for 32 edges and 1 on the 33rd cycle; then all registers read INIT_VAL (0), and rd1/rd2=0 throughout INIT.
REQ-036 Mux and latency check: ready; wa=5, regwrite=1, wbsel=00, alu_sum=32'h1234ABCD -> ra1=5 reads 32'h1234ABCD the next cycle; wbsel=01 with mem_data=32'hDEADBEEF to wa=6 -> reg6=32'hDEADBEEF.
REQ-037 Link and zero check: link=1, wa=7, wbsel=00, pc_plus4=32'h00400010 -> reg31=32'h00400010 and reg7 unchanged; wa=0, alu_sum=32'hFFFFFFFF -> rd1 at ra1=0 stays 0.
REQ-038 Suppression check: wbsel=11, regwrite=1, wa=8 -> reg8 unchanged; a write issued at cycle 10 during INIT -> dropped, and the register holds 0 after ready rises.
REQ-039 Reset mid-INIT check: assert reset at INIT cycle 20 -> clr_ptr restarts at 0 and ready rises 32 edges after that reset releases.
REQ-040 Bypass check: same-cycle write reg9=32'hCAFEF00D with ra2=9 -> rd2=32'hCAFEF00D when built with REGFILE_BYPASS_EN, and the old value when built without it.
